// File: rtl/instr_dispatch_fsm.sv
// Fetch/decode/dispatch sequencer driving one-hot start pulses to execution FSMs.
// Optional WAIT_DONE watchdog: define DISPATCH_WATCHDOG_EN.
module instr_dispatch_fsm #(
  parameter int PC_W        = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  output logic            imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [3:0]      start,
  output logic [5:0]      source,
  output logic [5:0]      dest,
  input  logic            done,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            wdog_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_MEM  = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]  state;
  logic [15:0] ir;
  logic [3:0]  op;
  logic [3:0]  start_oh;
  logic        op_exec;

  assign op         = ir[15:12];
  assign source     = ir[11:6];
  assign dest       = ir[5:0];
  assign imem_addr  = pc;
  assign imem_rd_en = (state == S_FETCH);
  assign busy       = (state != S_IDLE) && (state != S_HALT);

  always_comb begin
    start_oh = 4'b0000;
    case (op)
      4'h1:    start_oh = 4'b0001;
      4'h2:    start_oh = 4'b0010;
      4'h3:    start_oh = 4'b0100;
      4'h4:    start_oh = 4'b1000;
      default: start_oh = 4'b0000;
    endcase
  end

  assign op_exec = (start_oh != 4'b0000);

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wcnt;
  logic            wdog_q;

  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      start   <= 4'b0000;
      halted  <= 1'b0;
      illegal <= 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
      wcnt    <= '0;
      wdog_q  <= 1'b0;
`endif
    end else begin
      start <= 4'b0000;
      unique case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          ir    <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (op == OP_NOP) begin
            pc    <= pc + 1'b1;
            state <= run ? S_FETCH : S_IDLE;
          end else if (op_exec) begin
            start <= start_oh;
            state <= S_ISSUE;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_ISSUE: begin
`ifdef DISPATCH_WATCHDOG_EN
          wcnt  <= '0;
`endif
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done) begin
            pc    <= pc + 1'b1;
            state <= run ? S_FETCH : S_IDLE;
          end
`ifdef DISPATCH_WATCHDOG_EN
          // pc is left on the instruction that never completed
          else if (wcnt == WD_LIM) begin
            wdog_q <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Bench for instr_dispatch_fsm: directed sequences, a vector table and
// randomized programs checked against an instruction-level model.
module tb_instr_dispatch_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic [3:0]  start;
  logic [5:0]  source;
  logic [5:0]  dest;
  logic        done = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic        wdog_err;

  instr_dispatch_fsm #(.PC_W(8), .WDOG_CYCLES(8)) dut (
    .clock(clk), .reset(rst), .run(run),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .start(start), .source(source), .dest(dest), .done(done),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

  // execution-FSM stand-in: pulses done a set number of cycles after start
  int lat = -1;
  bit rand_mode = 1'b0;
  int cnt = 0;
  int start_cnt = 0;
  logic [3:0] last_start = 4'b0;

  always @(negedge clk) begin
    if (rst) begin
      done = 1'b0;
      cnt = 0;
      last_start = 4'b0;
    end else begin
      done = 1'b0;
      if (start != 4'b0) begin
        start_cnt++;
        last_start = start;
        if (rand_mode) begin
          cnt = $urandom_range(1, 5);
          done = ($urandom % 2) == 1;
        end else if (lat > 0) cnt = lat;
        else cnt = 0;
      end else if (cnt == 1) begin
        done = 1'b1;
        cnt = 0;
      end else if (cnt > 1) cnt--;
    end
  end

  int pass_n = 0;
  int tot_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kinds: 0 rd_en, 1 start, 2 halted, 3 !busy, 4 pc==arg, 5 pc!=arg
  task automatic wait_for(input string nm, input int kind, input int budget, input int arg);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      case (kind)
        0: ok = imem_rd_en;
        1: ok = (start != 4'b0);
        2: ok = halted;
        3: ok = !busy;
        4: ok = (pc == arg[7:0]);
        default: ok = (pc != arg[7:0]);
      endcase
      if (ok) break;
    end
    if (!ok) begin
      tot_n++;
      $display("FAIL timeout %s: got no event want event within %0d cycles", nm, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    lat = -1;
    rand_mode = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] all_out();
    return {27'b0, start, imem_rd_en, busy, halted, illegal, wdog_err,
            pc, source, dest, imem_addr};
  endfunction

  typedef struct {
    logic [15:0] word;
    int          n_start;
    logic [3:0]  exp_start;
    logic        exp_ill;
    logic [7:0]  exp_pc;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [5:0] s;
    logic [5:0] d;
    logic [7:0] p;
  } exp_t;

  vec_t vecs [8];
  exp_t q[$];

  initial begin
    vecs[0] = '{16'h0ABC, 0, 4'b0000, 1'b0, 8'd1};
    vecs[1] = '{16'h1FC1, 1, 4'b0001, 1'b0, 8'd1};
    vecs[2] = '{16'h2042, 1, 4'b0010, 1'b0, 8'd1};
    vecs[3] = '{16'h3FFF, 1, 4'b0100, 1'b0, 8'd1};
    vecs[4] = '{16'h4001, 1, 4'b1000, 1'b0, 8'd1};
    vecs[5] = '{16'h5123, 0, 4'b0000, 1'b1, 8'd0};
    vecs[6] = '{16'hE000, 0, 4'b0000, 1'b1, 8'd0};
    vecs[7] = '{16'hF00F, 0, 4'b0000, 1'b0, 8'd0};

    foreach (mem[i]) mem[i] = 16'h0;

    // reset state
    step();
    chk("reset_outputs", all_out(), 64'h0);

    // MOV with done four cycles after start
    mem[0] = 16'h1046;
    mem[1] = 16'hF000;
    do_reset();
    lat = 4;
    run = 1'b1;
    wait_for("t1_fetch", 0, 10, 0);
    chk("t1_fetch_addr", {pc, imem_addr}, 16'h0000);
    step();
    step();
    chk("t1_no_early_start", start, 4'b0000);
    step();
    chk("t1_start", {start, source, dest}, {4'b0001, 6'd1, 6'd6});
    step();
    chk("t1_start_one_cycle", start, 4'b0000);
    chk("t1_pc_held", pc, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) break;
    end
    chk("t1_pc_after_done", {pc, 7'b0, imem_rd_en}, {8'd1, 8'd1});

    // NOP, ADD, HALT
    mem[0] = 16'h0000;
    mem[1] = 16'h2083;
    mem[2] = 16'hF000;
    do_reset();
    lat = 2;
    run = 1'b1;
    wait_for("t2_fetch", 0, 10, 0);
    step();
    step();
    step();
    chk("t2_nop_3cyc", {pc, 7'b0, imem_rd_en}, {8'd1, 8'd1});
    wait_for("t2_start", 1, 10, 0);
    chk("t2_add", {start, source, dest}, {4'b0010, 6'd2, 6'd3});
    wait_for("t2_halt", 2, 30, 0);
    chk("t2_halted", {busy, halted, illegal, pc}, {1'b0, 1'b1, 1'b0, 8'd2});
    repeat (5) step();
    chk("t2_frozen", {busy, halted, pc, imem_rd_en}, {1'b0, 1'b1, 8'd2, 1'b0});

    // illegal opcode at address 5
    foreach (mem[i]) mem[i] = 16'h0;
    mem[5] = 16'h7000;
    do_reset();
    start_cnt = 0;
    run = 1'b1;
    wait_for("t3_halt", 2, 40, 0);
    chk("t3_illegal", {illegal, halted, busy, pc}, {1'b1, 1'b1, 1'b0, 8'd5});
    chk("t3_no_start", start_cnt, 0);

    // single-instruction vector table, each followed by HALT
    foreach (vecs[k]) begin
      foreach (mem[i]) mem[i] = 16'h0;
      mem[0] = vecs[k].word;
      mem[1] = 16'hF000;
      do_reset();
      start_cnt = 0;
      lat = 2;
      run = 1'b1;
      wait_for($sformatf("vec%0d_halt", k), 2, 40, 0);
      chk($sformatf("vec%0d_starts", k), start_cnt, vecs[k].n_start);
      chk($sformatf("vec%0d_state", k),
          {last_start, illegal, halted, pc},
          {vecs[k].exp_start, vecs[k].exp_ill, 1'b1, vecs[k].exp_pc});
    end

    // pc wraps at 2^PC_W
    foreach (mem[i]) mem[i] = 16'h0;
    do_reset();
    run = 1'b1;
    wait_for("wrap_255", 4, 900, 255);
    wait_for("wrap_next", 5, 10, 255);
    chk("wrap_pc", pc, 8'd0);

    // run dropped while waiting for done
    mem[0] = 16'h3000;
    do_reset();
    lat = 3;
    run = 1'b1;
    wait_for("rd_start", 1, 10, 0);
    step();
    run = 1'b0;
    wait_for("rd_idle", 3, 20, 0);
    chk("rd_completed", {pc, halted, busy}, {8'd1, 1'b0, 1'b0});
    begin
      int fetches = 0;
      repeat (6) begin
        step();
        if (imem_rd_en) fetches++;
      end
      chk("rd_no_fetch", fetches, 0);
    end

    // asynchronous reset in WAIT_DONE, then in ISSUE
    mem[0] = 16'h1FFF;
    do_reset();
    lat = -1;
    run = 1'b1;
    wait_for("ar_start", 1, 10, 0);
    step();
    step();
    #2 rst = 1'b1;
    #1 chk("ar_waitdone_clear", all_out(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    wait_for("ar_refetch", 0, 10, 0);
    chk("ar_refetch_addr", imem_addr, 8'd0);
    wait_for("ar_start2", 1, 10, 0);
    rst = 1'b1;
    #1 chk("ar_issue_clear", all_out(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_for("ar_refetch2", 0, 10, 0);
    chk("ar_refetch2_pc", pc, 8'd0);

    // done withheld
    mem[0] = 16'h3000;
    mem[1] = 16'hF000;
    do_reset();
    lat = -1;
    run = 1'b1;
    wait_for("wd_start", 1, 10, 0);
`ifdef DISPATCH_WATCHDOG_EN
    begin
      int n = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        n++;
        if (halted) break;
      end
      chk("wd_cycles", n, 9);
      chk("wd_flags", {wdog_err, halted, busy, pc}, {1'b1, 1'b1, 1'b0, 8'd0});
    end
`else
    repeat (100) step();
    chk("wd_stuck", {wdog_err, halted, busy, pc}, {1'b0, 1'b0, 1'b1, 8'd0});
`endif

    // random programs against an instruction-level model
    for (int r = 0; r < 3; r++) begin
      int n;
      logic [3:0] prev;
      n = 30;
      q.delete();
      foreach (mem[i]) mem[i] = 16'h0;
      for (int i = 0; i < n; i++) begin
        logic [3:0] op;
        logic [11:0] f;
        exp_t e;
        op = 4'($urandom_range(0, 4));
        f = 12'($urandom);
        mem[i] = {op, f};
        if (op != 4'h0) begin
          e.st = 4'b0001 << (op - 4'h1);
          e.s = f[11:6];
          e.d = f[5:0];
          e.p = 8'(i);
          q.push_back(e);
        end
      end
      mem[n] = 16'hF000;
      do_reset();
      rand_mode = 1'b1;
      prev = 4'b0;
      for (int c = 0; c < 3000; c++) begin
        run = ($urandom % 4) != 0;
        step();
        if (start != 4'b0) begin
          chk("rnd_start_gap", prev, 4'b0);
          if (q.size() == 0) begin
            tot_n++;
            $display("FAIL rnd_extra_start: got %0h want none", start);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("rnd%0d_issue", r), {start, source, dest, pc},
                {e.st, e.s, e.d, e.p});
          end
        end
        prev = start;
        if (halted) break;
      end
      chk($sformatf("rnd%0d_end", r), {q.size(), halted, illegal, pc},
          {32'd0, 1'b1, 1'b0, 8'(n)});
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
